// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller:
//   - fetch_state_e : FSM state encoding (IDLE / REQ / WAIT / HOLD), 2 bits
//   - NOP_INSTR     : instruction shown in an empty output slot (addi x0,x0,0)
//   - DEFAULT_RESET_PC : default fetch address after reset
//   - word_align()  : clears the byte-offset bits of an address
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses are always word aligned; the low two bits of a
    // redirect target are dropped rather than trapped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_adder.sv
// -----------------------------------------------------------------------------
// adder_32b_4
// Sequential-PC incrementer: sum = a + 4, modulo 2^WIDTH (wraps at the top of
// the address space).
// Ports:
//   a   : input  address
//   sum : output address + 4
// -----------------------------------------------------------------------------
module adder_32b_4 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + WIDTH'(4);

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the fetch PC, issues one outstanding
// request at a time to a variable-latency instruction memory, and presents
// fetched instructions in a registered output slot feeding IF/ID. Handles
// decode stalls (slot holds, response parks in a hold buffer) and EX
// redirects (slot flushed, in-flight response squashed via a kill flag).
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   stall      : IF/ID must not advance this cycle
//   pc_sel_ex  : EX redirect this cycle (highest priority)
//   pc_ex      : redirect target (low two bits ignored)
//   imem_req   : request valid to imem
//   imem_addr  : request address (word aligned)
//   imem_ready : imem accepts the request this cycle
//   imem_valid : single-cycle response pulse
//   imem_instr : response instruction
//   if_valid   : output slot holds a valid instruction
//   if_pc      : PC of the slot instruction
//   if_instr   : slot instruction (NOP when empty)
//   busy       : request accepted, response outstanding
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            pc_sel_ex,
    input  logic [XLEN-1:0] pc_ex,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_instr,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            busy
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, fetch_pc_plus4;
    logic [XLEN-1:0] hold_instr_q;

    logic            slot_valid_q, slot_valid_d;
    logic [XLEN-1:0] slot_pc_q, slot_pc_d;
    logic [XLEN-1:0] slot_instr_q, slot_instr_d;

    // FSM-to-datapath strobes.
    logic load_mem;    // response goes straight into the slot
    logic load_hold;   // parked response moves into the slot
    logic store_hold;  // response parks in the hold buffer

    logic slot_loadable;
    logic slot_consume;

    // The slot can take a new instruction when it is empty or IF/ID is
    // taking the current one at this edge.
    assign slot_loadable = !slot_valid_q || !stall;
    assign slot_consume  = slot_valid_q && !stall;

    adder_32b_4 #(.WIDTH(XLEN)) u_pc_inc (
        .a   (fetch_pc_q),
        .sum (fetch_pc_plus4)
    );

    // -------------------------------------------------------------------------
    // Process 1: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic. A redirect overrides every transition; the
    // kill flag remembers that the outstanding response belongs to the old
    // path.
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        load_mem   = 1'b0;
        load_hold  = 1'b0;
        store_hold = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;

            S_REQ: begin
                // An unaccepted request just retargets next cycle; an
                // accepted one during a redirect fetched the old address.
                if (imem_ready) begin
                    state_d = S_WAIT;
                    kill_d  = pc_sel_ex;
                end
            end

            S_WAIT: begin
                if (imem_valid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    if (!pc_sel_ex && !kill_q) begin
                        if (slot_loadable) begin
                            load_mem = 1'b1;
                        end else begin
                            store_hold = 1'b1;
                            state_d    = S_HOLD;
                        end
                    end
                end else if (pc_sel_ex) begin
                    kill_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (pc_sel_ex) begin
                    state_d = S_REQ;
                end else if (slot_loadable) begin
                    load_hold = 1'b1;
                    state_d   = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: FSM outputs
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req  = (state_q == S_REQ);
        busy      = (state_q == S_WAIT);
        imem_addr = fetch_pc_q;
    end

    // -------------------------------------------------------------------------
    // Datapath: fetch PC and output slot
    // -------------------------------------------------------------------------
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;

        if (pc_sel_ex) begin
            fetch_pc_d   = {pc_ex[XLEN-1:2], 2'b00};
            slot_valid_d = 1'b0;
            slot_instr_d = XLEN'(NOP_INSTR);
        end else if (load_mem || load_hold) begin
            fetch_pc_d   = fetch_pc_plus4;
            slot_valid_d = 1'b1;
            slot_pc_d    = fetch_pc_q;
            slot_instr_d = load_mem ? imem_instr : hold_instr_q;
        end else if (slot_consume) begin
            slot_valid_d = 1'b0;
            slot_instr_d = XLEN'(NOP_INSTR);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q   <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_instr_q <= XLEN'(NOP_INSTR);
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
        end
    end

    // The hold buffer is occupied exactly when the FSM is in HOLD, and the
    // fetch PC does not move while it is occupied, so only the instruction
    // needs storing.
    // NOTE: this data register has no reset; its contents are never read
    // unless the FSM is in HOLD, which always writes it first.
    always_ff @(posedge clk) begin
        if (store_hold) begin
            hold_instr_q <= imem_instr;
        end
    end

    assign if_valid = slot_valid_q;
    assign if_pc    = slot_pc_q;
    assign if_instr = slot_instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. A behavioural imem answers requests with
// instr = addr ^ 32'hA5A5_0000 after a configurable latency. The driver pushes
// the expected in-order instruction stream into a scoreboard queue whenever it
// starts a new stream (reset or redirect); a monitor pops one entry each time
// IF/ID consumes the slot. A second instance with RESET_PC = 32'hFFFF_FFF8 and
// a zero-latency imem checks address wrap-around.
// Timing per cycle: imem models act at negedge, the driver at negedge+1,
// monitors at negedge+2; the DUT samples at posedge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] K    = 32'hA5A5_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pc_sel_ex;
    logic [31:0] pc_ex;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        busy;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_valid2;
    logic [31:0] imem_instr2;
    logic        if_valid2;
    logic [31:0] if_pc2;
    logic [31:0] if_instr2;
    logic        busy2;

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pc_sel_ex  (pc_sel_ex),
        .pc_ex      (pc_ex),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_valid (imem_valid),
        .imem_instr (imem_instr),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .busy       (busy)
    );

    fetch_ctrl #(.XLEN(32), .RESET_PC(RPC2)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .stall      (1'b0),
        .pc_sel_ex  (1'b0),
        .pc_ex      (32'h0),
        .imem_req   (imem_req2),
        .imem_addr  (imem_addr2),
        .imem_ready (1'b1),
        .imem_valid (imem_valid2),
        .imem_instr (imem_instr2),
        .if_valid   (if_valid2),
        .if_pc      (if_pc2),
        .if_instr   (if_instr2),
        .busy       (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- checking
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];

    // Program order from a start address: start, start+4, ... modulo 2^32.
    task automatic new_stream(input logic [31:0] start);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = e.pc ^ K;
            exp_q.push_back(e);
        end
    endtask

    // ---------------------------------------------------------- imem model #1
    int          ready_pct = 100;
    int          lat_min   = 1;
    int          lat_max   = 1;
    bit          pend      = 1'b0;
    int          cnt       = 0;
    logic [31:0] paddr     = '0;

    initial begin
        imem_ready = 1'b0;
        imem_valid = 1'b0;
        imem_instr = '0;
        forever begin
            @(negedge clk);
            imem_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_instr = paddr ^ K;
                    pend       = 1'b0;
                end
            end
            imem_ready = !pend && ($urandom_range(99) < ready_pct);
            if (imem_req && imem_ready) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = $urandom_range(lat_max, lat_min);
            end
        end
    end

    // ------------------------------------------------------------- monitor #1
    bit          outstanding = 1'b0;
    bit          tgt_pending = 1'b0;
    logic [31:0] tgt         = '0;
    bit          redir_last  = 1'b0;
    bit          hold_win    = 1'b0;
    int          hs_count    = 0;
    int          n_cons      = 0;

    initial begin
        exp_t e;
        bit   hs;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                outstanding = 1'b0;
                tgt_pending = 1'b0;
                redir_last  = 1'b0;
            end else begin
                check("busy_vs_outstanding", busy, outstanding);
                check("req_while_outstanding", imem_req && outstanding, 0);
                if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 0);
                if (redir_last) check("flush_after_redirect", if_valid, 0);

                hs = imem_req && imem_ready;
                if (hs && tgt_pending) begin
                    check("redirect_target_addr", imem_addr, tgt);
                    tgt_pending = 1'b0;
                end
                if (hs && hold_win) hs_count++;

                if (if_valid && !stall && !pc_sel_ex) begin
                    n_cons++;
                    check("sb_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("slot_pc", if_pc, e.pc);
                        check("slot_instr", if_instr, e.instr);
                    end
                end

                if (outstanding && imem_valid) outstanding = 1'b0;
                if (hs) outstanding = 1'b1;
                if (pc_sel_ex) begin
                    tgt_pending = 1'b1;
                    tgt         = {pc_ex[31:2], 2'b00};
                end
                redir_last = pc_sel_ex;
            end
        end
    end

    // ------------------------------- imem model #2 (zero latency) + monitor #2
    bit          pend2  = 1'b0;
    logic [31:0] paddr2 = '0;

    initial begin
        imem_valid2 = 1'b0;
        imem_instr2 = '0;
        forever begin
            @(negedge clk);
            imem_valid2 = pend2;
            imem_instr2 = paddr2 ^ K;
            pend2       = imem_req2;
            paddr2      = imem_addr2;
        end
    end

    logic [31:0] exp2 = RPC2;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                exp2 = RPC2;
            end else if (if_valid2) begin
                check("wrap_pc", if_pc2, exp2);
                check("wrap_instr", if_instr2, exp2 ^ K);
                exp2 = exp2 + 32'd4;
            end
        end
    end

    // ------------------------------------------------------------------ driver
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b0;
        stall     = 1'b0;
        pc_sel_ex = 1'b0;
        new_stream(32'h0);
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] t);
        pc_sel_ex = 1'b1;
        pc_ex     = t;
        new_stream({t[31:2], 2'b00});
        tick();
        pc_sel_ex = 1'b0;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return if_valid && (if_pc == 32'd8);
            1:       return busy;
            2:       return imem_req && imem_ready;
            3:       return imem_valid;
            default: return if_valid;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        int n = 0;
        while (!cond(which) && n < budget) begin
            tick();
            n++;
        end
        check(name, cond(which), 1);
    endtask

    task automatic set_lat(input int lo, input int hi, input int rp);
        lat_min   = lo;
        lat_max   = hi;
        ready_pct = rp;
    endtask

    initial begin
        int c0;
        rst       = 1'b0;
        stall     = 1'b0;
        pc_sel_ex = 1'b0;
        pc_ex     = '0;
        new_stream(32'h0);
        tick();

        // Zero-latency imem: one instruction every two cycles.
        set_lat(1, 1, 100);
        do_reset(2);
        wait_for(4, 10, "first_valid");
        c0 = n_cons;
        repeat (20) tick();
        check("throughput_2cyc", (n_cons - c0) >= 10, 1);

        // Three-cycle latency.
        set_lat(3, 3, 100);
        do_reset(2);
        repeat (40) tick();

        // Stall with pc=8 in the slot; next response parks in HOLD.
        set_lat(1, 1, 100);
        do_reset(2);
        wait_for(0, 40, "reach_pc8");
        stall    = 1'b1;
        hold_win = 1'b1;
        hs_count = 0;
        repeat (5) begin
            tick();
            check("stall_slot_valid", if_valid, 1);
            check("stall_slot_pc", if_pc, 32'd8);
        end
        stall    = 1'b0;
        hold_win = 1'b0;
        check("hold_single_request", hs_count, 1);
        repeat (10) tick();

        // Redirect during WAIT, two-cycle latency.
        set_lat(2, 2, 100);
        wait_for(1, 20, "wait_busy_a");
        redirect(32'h0000_0103);
        repeat (20) tick();

        // Redirect coinciding with the handshake, then with the response.
        set_lat(1, 1, 100);
        wait_for(2, 20, "wait_handshake");
        redirect(32'h0000_0200);
        repeat (10) tick();
        wait_for(3, 20, "wait_response");
        redirect(32'h0000_0300);
        repeat (10) tick();

        // Reset in the middle of WAIT.
        set_lat(3, 3, 100);
        wait_for(1, 20, "wait_busy_b");
        rst = 1'b0;
        new_stream(32'h0);
        tick();
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_imem_req", imem_req, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (20) tick();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0)
                set_lat(1, 1 + $urandom_range(3), 40 + $urandom_range(60));
            if ($urandom_range(999) < 3) begin
                do_reset(1 + $urandom_range(2));
            end else begin
                stall = ($urandom_range(99) < 30);
                if ($urandom_range(99) < 4) redirect($urandom);
                else tick();
            end
        end

        stall = 1'b0;
        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage: owns the fetch PC, issues single-outstanding requests to a variable-latency instruction memory, and presents fetched instructions to the IF/ID pipeline register.
- Handles decode stalls from the hazard unit and branch/jump redirects from EX, including squashing in-flight responses.
- Sits between the PC logic, the imem port, and if_id_pipeline_reg.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset, sampled on the rising clk edge).
- stall  input  1  hazard unit: IF/ID must not advance this cycle.
- pc_sel_ex  input  1  EX redirect (taken branch/jump) this cycle.
- pc_ex  input  XLEN  redirect target from EX.
- imem_req  output  1  request valid to imem.
- imem_addr  output  XLEN  request address; bits [1:0] always 0.
- imem_ready  input  1  imem accepts the request this cycle (req && ready = handshake).
- imem_valid  input  1  response valid; single-cycle pulse.
- imem_instr  input  XLEN  response instruction.
- if_valid  output  1  output slot holds a valid instruction.
- if_pc  output  XLEN  PC of the slot instruction.
- if_instr  output  XLEN  slot instruction.
- busy  output  1  a request is accepted but its response is not yet received (state WAIT).

Behaviour:
- Reset (rst=0 at edge): state=IDLE, fetch_pc=RESET_PC, kill=0, hold buffer empty, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), imem_req=0, busy=0.
- Output slot: registered. It is consumed at an edge where if_valid=1 and stall=0. It may be loaded at an edge where it is empty or being consumed. When consumed and not reloaded, if_valid goes to 0 and if_instr goes to NOP.
- States:
  - IDLE: next cycle goes to REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc. On imem_ready, go to WAIT.
  - WAIT: imem_req=0. On imem_valid:
    - if kill=1, discard the response, clear kill, go to REQ.
    - else if the slot is loadable, load {fetch_pc, imem_instr}, set fetch_pc+=4, go to REQ.
    - else store the response in the hold buffer and go to HOLD.
  - HOLD: imem_req=0. When the slot is loadable, move the hold buffer into the slot, set fetch_pc+=4, go to REQ.
- Minimum throughput: 1 instruction per 2 cycles with zero-latency imem (REQ accepted, valid next cycle). Full pipelining is out of scope.
- Redirect (pc_sel_ex=1) has priority over stall and every state:
  - Slot invalidated: if_valid=0, if_instr=NOP.
  - fetch_pc set to {pc_ex[31:2], 2'b00}.
  - Hold buffer dropped.
  - From REQ without ready: stay in REQ; the address changes next cycle (imem must tolerate an unaccepted address change).
  - REQ with imem_ready in the same cycle: the old-address request is accepted; go to WAIT with kill=1.
  - WAIT without imem_valid: set kill=1 and stay in WAIT.
  - WAIT with imem_valid in the same cycle: discard the response, go to REQ, kill=0.
  - HOLD or IDLE: go to REQ.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- imem_valid outside WAIT is ignored.
- Reset mid-transaction: return to IDLE immediately. Any later imem_valid is ignored because the controller is not in WAIT.

Decomposition:
- Shared include (fetch_defs.vh): state encodings IDLE/REQ/WAIT/HOLD (2-bit), NOP_INSTR=32'h0000_0013, RESET_PC default.
- Reuse the existing adder_32b_4 for fetch_pc+4.
- The rest (FSM, slot, hold buffer, kill flag) stays in one module.

Test Plan:
- Reset, then zero-latency imem returning instr=addr^32'hA5A5_0000 → slot shows pc 0,4,8,… every 2 cycles; if_instr matches; if_valid=1.
- imem with 3-cycle response latency → busy=1 for 3 cycles per fetch; PCs 0,4,8 in order; no duplicates or gaps.
- stall held 5 cycles after pc=8 loaded → slot holds pc=8; next response parks in HOLD; after release, pc=8 is consumed, then pc=12, with no extra request issued while in HOLD.
- pc_sel_ex=1, pc_ex=32'h0000_0103 during WAIT with 2-cycle latency → in-flight response discarded; next imem_addr=32'h0000_0100; if_valid=0 until pc 0x100 arrives.
- Redirect in the same cycle as imem_ready, and separately in the same cycle as imem_valid → no stale instruction ever reaches the slot; next request goes to the target.
- RESET_PC=32'hFFFF_FFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. Assert rst=0 mid-WAIT → all outputs return to reset values on the next edge.
